core_selftest_seq: RTL and testbench
====================================

Name: core_selftest_seq

Overview:
Synthesizable on-chip replacement for the bench's load/start/wait/check loop. It runs NUM_TESTS Lisp evaluation tests back-to-back against `core`. For each test it resets the core, clears and preloads core memory from a vector ROM, drives the expression word and pulses start, then waits for Halt/Error under a watchdog. It compares val against the expected word and accumulates pass/fail results for display on the LEDs/7-seg path.

Parameters:
WORD_W, 16, memory/expression word width
ADDR_W, 8, core memory address width (clear sweep covers 2**ADDR_W words)
NUM_TESTS, 4, number of test records in the vector ROM
IMAGE_DEPTH, 16, max (addr,data) pairs per test
ROM_ADDR_W, 10, vector ROM address width
TIMEOUT_CYCLES, 4096, max cycles in RUN before timeout
CORE_RST_CYCLES, 2, cycles core_hold is asserted per test
ERR_W, 8, width of core error code

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
go  in  1  one-cycle pulse: start full run; ignored while busy
rom_addr  out  ROM_ADDR_W  vector ROM read address
rom_data  in  WORD_W  vector ROM data, valid exactly 1 cycle after rom_addr
mem_we  out  1  core memory write enable
mem_addr  out  ADDR_W  core memory write address
mem_wdata  out  WORD_W  core memory write data
core_hold  out  1  active-high reset to core
core_expr  out  WORD_W  expression word (drives core switches input)
core_start  out  1  one-cycle start pulse to core
core_halt  in  1  core in Halt
core_error  in  1  core in Error
core_val  in  WORD_W  core result
core_err_code  in  ERR_W  core error code
busy  out  1  run in progress
done  out  1  run finished; held until next accepted go or reset
pass_count  out  $clog2(NUM_TESTS+1)  tests passed
fail_count  out  $clog2(NUM_TESTS+1)  tests failed
fail_idx  out  $clog2(NUM_TESTS)  index of first failing test
fail_kind  out  3  fail_kind_t of first failure (NONE until a failure)
fail_info  out  WORD_W  first failure: core_val (MISMATCH), zero-extended core_err_code (CORE_ERR), 0 (TIMEOUT/FORMAT)

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; every output 0, including core_hold, core_expr, rom_addr, fail_kind=NONE. This applies mid-run too: no partial memory writes continue.
- ROM record layout, records packed contiguously from address 0: word0 = N (pair count), word1 = expr, word2 = expected, then N pairs of (addr word, low ADDR_W bits used; data word).
- Each ROM word costs 2 cycles: present the address, then capture the data.
- States and transitions:
  - IDLE: go -> RST_CORE. On go, clear the counters, fail_* and done, and set busy=1.
  - RST_CORE: core_hold=1 for CORE_RST_CYCLES, then CLEAR.
  - CLEAR: mem_we=1, mem_wdata=0, mem_addr sweeps 0..2**ADDR_W-1 one per cycle (256 cycles at defaults), then HDR.
  - HDR: fetch N, expr, expected.
    - If N > IMAGE_DEPTH: record FORMAT failure, fail_count+1, abort the remaining tests -> DONE.
    - N=0 skips LOAD.
  - LOAD: per pair, fetch addr then data, then one mem_we cycle. Later writes to the same address win.
  - SETTLE: core_expr=expr held for 2 cycles.
  - START: core_start=1 for exactly one cycle.
  - RUN: each cycle, in priority order core_error > core_halt > timeout. The watchdog counts from the cycle after START. Timeout fires when the count reaches TIMEOUT_CYCLES-1 with neither input set. A halt in that same cycle counts as a halt.
  - CHECK:
    - Halt with core_val == expected: pass_count+1.
    - Otherwise fail_count+1 with kind MISMATCH, CORE_ERR or TIMEOUT. fail_idx, fail_kind and fail_info are latched only on the first failure.
  - NEXT: if test index == NUM_TESTS-1 -> DONE, else rom pointer advances past the record -> RST_CORE.
  - DONE: busy=0, done=1, core_hold=0, core_expr holds its last value -> IDLE.
- A go arriving in the same cycle as the DONE->IDLE transition is ignored. A go is accepted only while in IDLE.
- Counters never wrap: pass_count + fail_count <= NUM_TESTS.
- The ROM pointer wraps modulo 2**ROM_ADDR_W. Overrun is a vector authoring error and is not detected.
- core_expr stays 0 until the first SETTLE.

Decomposition:
- lisp_defs package: fail_kind_t (NONE, MISMATCH, CORE_ERR, TIMEOUT, FORMAT) and record offset constants HDR_N=0, HDR_EXPR=1, HDR_EXP=2, PAIR_BASE=3.
- State enum stays local to the module.
- One sub-module, selftest_watchdog: parametrised counter with clr/en inputs and an expired output.

Test Plan:
- NUM_TESTS=1; record {N=1, expr={0,TYPE_NUMBER,12'h001}, exp=DEAD, (1,DEAD)}; go -> done=1, pass_count=1, fail_count=0, fail_kind=NONE.
- NUM_TESTS=2; test0 as above plus test1 cons {N=4, expr={0,TYPE_CONS,12'h004}, exp=same, (1,BEEF),(2,DEAD),(3,0001),(4,0002)} -> pass_count=2. Also check mem_we high for exactly 256 cycles per CLEAR and exactly one core_start per test.
- Expected word set to DEAE on the number test -> fail_count=1, fail_idx=0, fail_kind=MISMATCH, fail_info=DEAD.
- Core model never halts, TIMEOUT_CYCLES=16 -> exactly 16 RUN cycles, fail_kind=TIMEOUT. A second model asserting core_error with code 8'h03 together with core_halt -> CORE_ERR, fail_info=0003.
- Record with N=IMAGE_DEPTH+1 -> FORMAT failure, fail_count=1, remaining tests skipped.
- Reset asserted during LOAD -> all outputs 0 next cycle. A go while busy has no effect; a fresh go after reset completes the run normally.

Source files
------------

// File: rtl/core_selftest_seq_pkg.sv
// Shared definitions for the core self-test sequencer: failure kinds and
// the word offsets of a vector ROM test record.
package lisp_defs;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        MISMATCH = 3'd1,
        CORE_ERR = 3'd2,
        TIMEOUT  = 3'd3,
        FORMAT   = 3'd4
    } fail_kind_t;

    localparam int unsigned HDR_N     = 0;
    localparam int unsigned HDR_EXPR  = 1;
    localparam int unsigned HDR_EXP   = 2;
    localparam int unsigned PAIR_BASE = 3;

endpackage

// File: rtl/core_selftest_seq_if.sv
// Connection between the self-test sequencer (master) and the Lisp core with
// its memory write port (slave).
interface core_selftest_seq_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              core_hold;
    logic [WORD_W-1:0] core_expr;
    logic              core_start;
    logic              core_halt;
    logic              core_error;
    logic [WORD_W-1:0] core_val;
    logic [ERR_W-1:0]  core_err_code;

    modport master (
        output mem_we, mem_addr, mem_wdata, core_hold, core_expr, core_start,
        input  core_halt, core_error, core_val, core_err_code
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, core_hold, core_expr, core_start,
        output core_halt, core_error, core_val, core_err_code
    );
endinterface

// File: rtl/core_selftest_seq_watchdog.sv
// Run watchdog: counts enabled cycles after a clear and flags the cycle in
// which the count reaches LIMIT-1.
module selftest_watchdog #(
    parameter  int LIMIT = 4096,
    localparam int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/core_selftest_seq.sv
// On-chip self-test sequencer: for each ROM record it resets the core, clears and
// preloads core memory, starts an evaluation and scores the result.
module core_selftest_seq
    import lisp_defs::*;
#(
    parameter  int WORD_W          = 16,
    parameter  int ADDR_W          = 8,
    parameter  int NUM_TESTS       = 4,
    parameter  int IMAGE_DEPTH     = 16,
    parameter  int ROM_ADDR_W      = 10,
    parameter  int TIMEOUT_CYCLES  = 4096,
    parameter  int CORE_RST_CYCLES = 2,
    parameter  int ERR_W           = 8,
    localparam int CNT_W           = $clog2(NUM_TESTS + 1),
    localparam int IDX_W           = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0]     rom_data,
    core_selftest_seq_if.master   core_if,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pass_count,
    output logic [CNT_W-1:0]      fail_count,
    output logic [IDX_W-1:0]      fail_idx,
    output fail_kind_t            fail_kind,
    output logic [WORD_W-1:0]     fail_info
);
    localparam int RC_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_CORE, S_CLEAR, S_HDR, S_LOAD, S_SETTLE,
        S_START, S_RUN, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t                state_q;
    logic [ROM_ADDR_W-1:0] rom_addr_q;
    logic                  fetch_ph_q;
    logic [1:0]            hdr_cnt_q;
    logic                  pair_ph_q;
    logic [WORD_W-1:0]     pair_cnt_q;
    logic [WORD_W-1:0]     n_q;
    logic [WORD_W-1:0]     expr_q;
    logic [WORD_W-1:0]     exp_q;
    logic [ADDR_W-1:0]     ld_addr_q;
    logic [RC_W-1:0]       rst_cnt_q;
    logic                  settle_q;
    logic [IDX_W-1:0]      test_idx_q;
    fail_kind_t            res_kind_q;
    logic [WORD_W-1:0]     res_val_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [WORD_W-1:0]     mem_wdata_q;
    logic                  core_hold_q;
    logic [WORD_W-1:0]     core_expr_q;
    logic                  core_start_q;
    logic                  busy_q;
    logic                  done_q;
    logic [CNT_W-1:0]      pass_q;
    logic [CNT_W-1:0]      fail_q;
    logic [IDX_W-1:0]      fail_idx_q;
    fail_kind_t            fail_kind_q;
    logic [WORD_W-1:0]     fail_info_q;

    logic [ERR_W-1:0]      err_code;
    logic                  wd_expired;

    assign err_code = core_if.core_err_code;

    selftest_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == S_START),
        .en_i      (state_q == S_RUN),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            fetch_ph_q   <= 1'b0;
            hdr_cnt_q    <= '0;
            pair_ph_q    <= 1'b0;
            pair_cnt_q   <= '0;
            rst_cnt_q    <= '0;
            settle_q     <= 1'b0;
            test_idx_q   <= '0;
            res_kind_q   <= NONE;
            res_val_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_hold_q  <= 1'b0;
            core_expr_q  <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= '0;
            fail_q       <= '0;
            fail_idx_q   <= '0;
            fail_kind_q  <= NONE;
            fail_info_q  <= '0;
        end else begin
            mem_we_q     <= 1'b0;
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (go) begin
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    pass_q      <= '0;
                    fail_q      <= '0;
                    fail_idx_q  <= '0;
                    fail_kind_q <= NONE;
                    fail_info_q <= '0;
                    rom_addr_q  <= '0;
                    test_idx_q  <= '0;
                    core_hold_q <= 1'b1;
                    rst_cnt_q   <= '0;
                    state_q     <= S_RST_CORE;
                end
                S_RST_CORE: if (rst_cnt_q == RC_W'(CORE_RST_CYCLES - 1)) begin
                    core_hold_q <= 1'b0;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    state_q     <= S_CLEAR;
                end else begin
                    rst_cnt_q <= rst_cnt_q + RC_W'(1);
                end
                S_CLEAR: if (mem_addr_q == '1) begin
                    fetch_ph_q <= 1'b0;
                    hdr_cnt_q  <= '0;
                    state_q    <= S_HDR;
                end else begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= mem_addr_q + ADDR_W'(1);
                end
                // ROM words take two cycles: address presented, then data captured.
                S_HDR: if (!fetch_ph_q) begin
                    fetch_ph_q <= 1'b1;
                end else begin
                    fetch_ph_q <= 1'b0;
                    rom_addr_q <= rom_addr_q + ROM_ADDR_W'(1);
                    hdr_cnt_q  <= hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'(HDR_N)) begin
                        n_q <= rom_data;
                    end else if (hdr_cnt_q == 2'(HDR_EXPR)) begin
                        expr_q <= rom_data;
                    end else if (hdr_cnt_q == 2'(PAIR_BASE - 1)) begin
                        exp_q <= rom_data;
                        if (n_q > WORD_W'(IMAGE_DEPTH)) begin
                            fail_q <= fail_q + CNT_W'(1);
                            if (fail_kind_q == NONE) begin
                                fail_idx_q  <= test_idx_q;
                                fail_kind_q <= FORMAT;
                                fail_info_q <= '0;
                            end
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (n_q == '0) begin
                            settle_q    <= 1'b0;
                            core_expr_q <= expr_q;
                            state_q     <= S_SETTLE;
                        end else begin
                            pair_ph_q  <= 1'b0;
                            pair_cnt_q <= '0;
                            state_q    <= S_LOAD;
                        end
                    end
                end
                // The write for a pair overlaps the address phase of the next fetch.
                S_LOAD: if (!fetch_ph_q) begin
                    fetch_ph_q <= 1'b1;
                end else begin
                    fetch_ph_q <= 1'b0;
                    rom_addr_q <= rom_addr_q + ROM_ADDR_W'(1);
                    if (!pair_ph_q) begin
                        ld_addr_q <= rom_data[ADDR_W-1:0];
                        pair_ph_q <= 1'b1;
                    end else begin
                        pair_ph_q   <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ld_addr_q;
                        mem_wdata_q <= rom_data;
                        pair_cnt_q  <= pair_cnt_q + WORD_W'(1);
                        if (pair_cnt_q == n_q - WORD_W'(1)) begin
                            settle_q    <= 1'b0;
                            core_expr_q <= expr_q;
                            state_q     <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: if (settle_q) begin
                    core_start_q <= 1'b1;
                    state_q      <= S_START;
                end else begin
                    settle_q <= 1'b1;
                end
                S_START: state_q <= S_RUN;
                S_RUN: begin
                    if (core_if.core_error) begin
                        res_kind_q <= CORE_ERR;
                        res_val_q  <= WORD_W'(err_code);
                        state_q    <= S_CHECK;
                    end else if (core_if.core_halt) begin
                        res_kind_q <= NONE;
                        res_val_q  <= core_if.core_val;
                        state_q    <= S_CHECK;
                    end else if (wd_expired) begin
                        res_kind_q <= TIMEOUT;
                        res_val_q  <= '0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (res_kind_q == NONE && res_val_q == exp_q) begin
                        pass_q <= pass_q + CNT_W'(1);
                    end else begin
                        fail_q <= fail_q + CNT_W'(1);
                        if (fail_kind_q == NONE) begin
                            fail_idx_q  <= test_idx_q;
                            fail_kind_q <= (res_kind_q == NONE) ? MISMATCH : res_kind_q;
                            fail_info_q <= res_val_q;
                        end
                    end
                    state_q <= S_NEXT;
                end
                S_NEXT: if (test_idx_q == IDX_W'(NUM_TESTS - 1)) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    test_idx_q  <= test_idx_q + IDX_W'(1);
                    core_hold_q <= 1'b1;
                    rst_cnt_q   <= '0;
                    state_q     <= S_RST_CORE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr           = rom_addr_q;
    assign core_if.mem_we     = mem_we_q;
    assign core_if.mem_addr   = mem_addr_q;
    assign core_if.mem_wdata  = mem_wdata_q;
    assign core_if.core_hold  = core_hold_q;
    assign core_if.core_expr  = core_expr_q;
    assign core_if.core_start = core_start_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign pass_count         = pass_q;
    assign fail_count         = fail_q;
    assign fail_idx           = fail_idx_q;
    assign fail_kind          = fail_kind_q;
    assign fail_info          = fail_info_q;
endmodule

// File: tb/tb_core_selftest_seq.sv
// Directed bench for core_selftest_seq: a vector ROM, a toy core with its own
// memory, and hand-computed expectations for each run.
module tb_core_selftest_seq;
    import lisp_defs::*;

    localparam logic [2:0] TYPE_NUMBER = 3'd1;
    localparam logic [2:0] TYPE_CONS   = 3'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go  = 1'b0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy, done;
    logic [1:0]  pass_count, fail_count;
    logic [0:0]  fail_idx;
    fail_kind_t  fail_kind;
    logic [15:0] fail_info;

    core_selftest_seq_if #(.WORD_W(16), .ADDR_W(8), .ERR_W(8)) cif ();

    core_selftest_seq #(
        .WORD_W(16), .ADDR_W(8), .NUM_TESTS(2), .IMAGE_DEPTH(16), .ROM_ADDR_W(10),
        .TIMEOUT_CYCLES(16), .CORE_RST_CYCLES(2), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .rom_addr(rom_addr), .rom_data(rom_data),
        .core_if(cif), .busy(busy), .done(done), .pass_count(pass_count),
        .fail_count(fail_count), .fail_idx(fail_idx), .fail_kind(fail_kind),
        .fail_info(fail_info)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:1023];
    int          wp;
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Toy core: number -> mem[a]; cons at a -> mem[mem[a-1] + 1].
    logic [15:0] cmem [0:255];
    logic        cnt_clr = 1'b0;
    logic        active;
    int unsigned run_cnt;
    int unsigned halt_dly = 3;
    logic        never_halt = 1'b0;
    logic        err_mode = 1'b0;
    int          we_cnt, zero_we_cnt, start_cnt;
    logic [7:0]  a_m, p_m;
    logic [15:0] val_m;

    always @(posedge clk) begin
        if (cnt_clr) begin
            we_cnt      <= 0;
            zero_we_cnt <= 0;
            start_cnt   <= 0;
            for (int i = 0; i < 256; i++) cmem[i] <= 16'hFFFF;
        end else begin
            if (cif.mem_we) begin
                cmem[cif.mem_addr] <= cif.mem_wdata;
                we_cnt <= we_cnt + 1;
                if (cif.mem_wdata == 16'h0000) zero_we_cnt <= zero_we_cnt + 1;
            end
            if (cif.core_start) start_cnt <= start_cnt + 1;
        end
        if (!rst || cif.core_hold) begin
            active <= 1'b0;
        end else if (cif.core_start) begin
            active  <= 1'b1;
            run_cnt <= 0;
        end else if (active) begin
            run_cnt <= run_cnt + 1;
        end
    end

    always_comb begin
        a_m   = cif.core_expr[7:0];
        p_m   = cmem[a_m - 8'd1][7:0] + 8'd1;
        val_m = (cif.core_expr[14:12] == TYPE_CONS) ? cmem[p_m] : cmem[a_m];
    end

    assign cif.core_halt     = active && !never_halt && (run_cnt >= halt_dly);
    assign cif.core_error    = active && err_mode && (run_cnt >= halt_dly);
    assign cif.core_err_code = err_mode ? 8'h03 : 8'h00;
    assign cif.core_val      = val_m;

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
        wp = 0;
    endtask

    task automatic put(input logic [15:0] w);
        rom[wp] = w;
        wp++;
    endtask

    task automatic rom_std(input logic [15:0] exp0);
        rom_clear();
        put(16'd1); put({1'b0, TYPE_NUMBER, 12'h001}); put(exp0);
        put(16'd1); put(16'hDEAD);
        put(16'd4); put({1'b0, TYPE_CONS, 12'h004}); put(16'hDEAD);
        put(16'd1); put(16'hBEEF); put(16'd2); put(16'hDEAD);
        put(16'd3); put(16'h0001); put(16'd4); put(16'h0002);
    endtask

    task automatic clr_counts();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        chk_eq("done", done, 1);
        chk_eq("busy_end", busy, 0);
    endtask

    task automatic run_seq();
        clr_counts();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done();
    endtask

    initial begin
        rom_clear();
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_hold", cif.core_hold, 0);
        chk_eq("rst_rom_addr", rom_addr, 0);
        chk_eq("rst_kind", fail_kind, NONE);
        chk_eq("rst_expr", cif.core_expr, 0);
        rst = 1'b1;
        @(negedge clk);

        // Two passing tests; a go while busy must not restart the run.
        rom_std(16'hDEAD);
        clr_counts();
        go = 1'b1; @(negedge clk); go = 1'b0;
        repeat (30) @(negedge clk);
        chk_eq("busy_run", busy, 1);
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_done();
        chk_eq("a_pass", pass_count, 2);
        chk_eq("a_fail", fail_count, 0);
        chk_eq("a_kind", fail_kind, NONE);
        chk_eq("a_we_cycles", we_cnt, 517);
        chk_eq("a_clear_cycles", zero_we_cnt, 512);
        chk_eq("a_starts", start_cnt, 2);
        chk_eq("a_mem_cleared", cmem[200], 16'h0000);
        chk_eq("a_expr_held", cif.core_expr, 16'h2004);
        chk_eq("a_hold_off", cif.core_hold, 0);

        // Expected word off by one on the number test.
        rom_std(16'hDEAE);
        run_seq();
        chk_eq("b_pass", pass_count, 1);
        chk_eq("b_fail", fail_count, 1);
        chk_eq("b_idx", fail_idx, 0);
        chk_eq("b_kind", fail_kind, MISMATCH);
        chk_eq("b_info", fail_info, 16'hDEAD);

        // Halt on the last watchdog cycle still counts as a halt.
        rom_std(16'hDEAD);
        halt_dly = 15;
        run_seq();
        chk_eq("c_edge_pass", pass_count, 2);
        chk_eq("c_edge_fail", fail_count, 0);

        // One cycle later is a timeout: exactly 16 RUN cycles.
        halt_dly = 16;
        run_seq();
        chk_eq("c_to_pass", pass_count, 0);
        chk_eq("c_to_fail", fail_count, 2);
        chk_eq("c_to_kind", fail_kind, TIMEOUT);
        chk_eq("c_to_info", fail_info, 0);
        chk_eq("c_to_starts", start_cnt, 2);

        // Error wins over a simultaneous halt.
        halt_dly = 2;
        err_mode = 1'b1;
        run_seq();
        chk_eq("d_fail", fail_count, 2);
        chk_eq("d_kind", fail_kind, CORE_ERR);
        chk_eq("d_info", fail_info, 16'h0003);
        err_mode = 1'b0;
        halt_dly = 3;

        // Oversized image aborts the whole run.
        rom_std(16'hDEAD);
        rom[0] = 16'd17;
        run_seq();
        chk_eq("e_pass", pass_count, 0);
        chk_eq("e_fail", fail_count, 1);
        chk_eq("e_idx", fail_idx, 0);
        chk_eq("e_kind", fail_kind, FORMAT);
        chk_eq("e_info", fail_info, 0);
        chk_eq("e_starts", start_cnt, 0);

        // Reset in the middle of test 1 LOAD, then a clean rerun.
        rom_std(16'hDEAD);
        clr_counts();
        go = 1'b1; @(negedge clk); go = 1'b0;
        for (int i = 0; i < 2000 && rom_addr != 10'd10; i++) @(negedge clk);
        chk_eq("f_reach_load", rom_addr, 10);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("f_busy", busy, 0);
        chk_eq("f_we", cif.mem_we, 0);
        chk_eq("f_mem_addr", cif.mem_addr, 0);
        chk_eq("f_rom_addr", rom_addr, 0);
        chk_eq("f_expr", cif.core_expr, 0);
        chk_eq("f_pass", pass_count, 0);
        rst = 1'b1;
        @(negedge clk);
        run_seq();
        chk_eq("f_rerun_pass", pass_count, 2);
        chk_eq("f_rerun_starts", start_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
